result_readback: RTL and testbench

Drains convolution results from output memory 0 to the MCU over the GPIO bus, one word per MCU request. Sits directly downstream of the convolution top level: armed by the processing FSM's end-of-processing pulse, it owns the memory-0 read address while active and presents each result on the GPIO input word. A toggle handshake paces the transfer, so the MCU can poll at any rate.

---
 rtl/result_readback_pkg.sv | 26 ++
 rtl/result_readback_if.sv | 42 ++++
 rtl/result_readback_toggle_edge_det.sv | 31 +++
 rtl/result_readback.sv | 102 ++++++++++
 tb/tb_result_readback.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/result_readback_pkg.sv
// -----------------------------------------------------------------------------
// result_readback_pkg
// Shared constants for the result readback path: default widths for the
// memory address, result word and word-count, plus the FSM state encoding
// used by the readback FSM and exposed on its debug state output.
// -----------------------------------------------------------------------------
package result_readback_pkg;

    localparam int NB_ADDRESS = 10;   // memory address width
    localparam int RAM_WIDTH  = 13;   // result word width
    localparam int NB_IMAGE   = 10;   // word-count width

    localparam int NB_STATE = 3;

    localparam logic [NB_STATE-1:0] ST_IDLE  = 3'd0;
    localparam logic [NB_STATE-1:0] ST_ARMED = 3'd1;
    localparam logic [NB_STATE-1:0] ST_READ  = 3'd2;
    localparam logic [NB_STATE-1:0] ST_LATCH = 3'd3;
    localparam logic [NB_STATE-1:0] ST_DONE  = 3'd4;

    // The block owns the memory-0 read port while in any of these states.
    function automatic logic state_is_busy(input logic [NB_STATE-1:0] st);
        return (st == ST_ARMED) || (st == ST_READ) || (st == ST_LATCH);
    endfunction

endpackage

// File: rtl/result_readback_if.sv
// -----------------------------------------------------------------------------
// result_readback_if
// Bundles the readback control inputs, the MCU toggle handshake, the memory-0
// read port and the status outputs.
//
// Handshake: every level change of i_req asks for one word. When the word is
// on o_data, o_ack has been toggled so that it equals i_req again. The MCU
// waits for o_ack == i_req before reading o_data and issuing the next toggle.
//
//   slave  : the readback block (drives o_*, o_state)
//   master : the environment (FSM, MCU, memory) driving i_*
// -----------------------------------------------------------------------------
interface result_readback_if;
    import result_readback_pkg::*;

    logic                  i_start;
    logic [NB_IMAGE-1:0]   i_length;
    logic                  i_abort;
    logic                  i_req;
    logic [RAM_WIDTH-1:0]  i_mem_data;
    logic [NB_ADDRESS-1:0] o_readAdd;
    logic                  o_rd_en;
    logic [RAM_WIDTH-1:0]  o_data;
    logic                  o_ack;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_overrun;
    logic [NB_STATE-1:0]   o_state;    // debug: current FSM state

    modport slave (
        input  i_start, i_length, i_abort, i_req, i_mem_data,
        output o_readAdd, o_rd_en, o_data, o_ack, o_busy, o_done, o_overrun,
               o_state
    );

    modport master (
        output i_start, i_length, i_abort, i_req, i_mem_data,
        input  o_readAdd, o_rd_en, o_data, o_ack, o_busy, o_done, o_overrun,
               o_state
    );

endinterface

// File: rtl/result_readback_toggle_edge_det.sv
// -----------------------------------------------------------------------------
// toggle_edge_det
// Detects a level change on a toggle-encoded request. The input is registered
// every cycle; toggled is high while the live input differs from the
// registered copy, i.e. for the one cycle in which a new level first appears.
//
//   clk     in  clock
//   rst_n   in  asynchronous active-low reset (registered copy -> 0)
//   tgl     in  toggle input
//   toggled out input differs from its registered copy
// -----------------------------------------------------------------------------
module toggle_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic tgl,
    output logic toggled
);

    logic tgl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgl_q <= 1'b0;
        end else begin
            tgl_q <= tgl;
        end
    end

    assign toggled = tgl ^ tgl_q;

endmodule

// File: rtl/result_readback.sv
// -----------------------------------------------------------------------------
// result_readback
// Drains convolution results from output memory 0 to the MCU, one word per
// request toggle. Armed by the end-of-processing pulse, it reads word `count`
// from memory, holds it on o_data and toggles o_ack, until `len` words have
// been returned. The memory-0 read port is muxed by the parent: this block
// drives it while o_busy is high.
//
//   i_CLK    in  clock
//   i_rst_n  in  asynchronous active-low reset
//   bus      slave modport of result_readback_if (controls, handshake,
//            memory read port, status, debug state)
// -----------------------------------------------------------------------------
module result_readback
    import result_readback_pkg::*;
(
    input  logic              i_CLK,
    input  logic              i_rst_n,
    result_readback_if.slave  bus
);

    logic [NB_STATE-1:0]   state;
    logic [NB_IMAGE-1:0]   len;
    logic [NB_IMAGE-1:0]   count;
    logic [NB_IMAGE-1:0]   count_inc;
    logic [NB_ADDRESS-1:0] addr;
    logic [RAM_WIDTH-1:0]  data;
    logic                  ack;
    logic                  overrun;
    logic                  req_edge;

    toggle_edge_det u_req_det (
        .clk     (i_CLK),
        .rst_n   (i_rst_n),
        .tgl     (bus.i_req),
        .toggled (req_edge)
    );

    // count < len <= 2^NB_IMAGE - 1 inside a run, so this never overflows.
    assign count_inc = count + 1'b1;

    always_ff @(posedge i_CLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            len     <= '0;
            count   <= '0;
            addr    <= '0;
            data    <= '0;
            ack     <= 1'b0;
            overrun <= 1'b0;
        end else if (bus.i_abort) begin
            // data and ack hold so the MCU's view of the handshake stays valid.
            state   <= ST_IDLE;
            count   <= '0;
            addr    <= '0;
            overrun <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // Request edges here are ignored and never flag overrun.
                    if (bus.i_start) begin
                        len     <= bus.i_length;
                        count   <= '0;
                        addr    <= '0;
                        overrun <= 1'b0;
                        state   <= (bus.i_length == '0) ? ST_DONE : ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (req_edge) begin
                        // Address register is loaded so it is valid in READ and
                        // still shows the last word's address after the run.
                        addr  <= count[NB_ADDRESS-1:0];
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (req_edge) overrun <= 1'b1;
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    if (req_edge) overrun <= 1'b1;
                    data  <= bus.i_mem_data;
                    ack   <= ~ack;
                    count <= count_inc;
                    state <= (count_inc == len) ? ST_DONE : ST_ARMED;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_readAdd = addr;
    assign bus.o_rd_en   = (state == ST_READ);
    assign bus.o_data    = data;
    assign bus.o_ack     = ack;
    assign bus.o_busy    = state_is_busy(state);
    assign bus.o_done    = (state == ST_DONE);
    assign bus.o_overrun = overrun;
    assign bus.o_state   = state;

endmodule

// File: tb/tb_result_readback.sv
// -----------------------------------------------------------------------------
// tb_result_readback
// Directed bench for result_readback: memory-0 model, request driver,
// scoreboard of expected words/addresses/request cycles, and a monitor that
// checks every read strobe and every acknowledge against the scoreboard.
// -----------------------------------------------------------------------------
module tb_result_readback;
    import result_readback_pkg::*;

    logic clk;
    logic rst_n;

    result_readback_if bus ();

    result_readback dut (
        .i_CLK   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // ------------------------------------------------------------------
    // clock / reset
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ------------------------------------------------------------------
    // memory-0 model: data valid the cycle after the read strobe
    // ------------------------------------------------------------------
    logic [RAM_WIDTH-1:0] mem [0:(1<<NB_ADDRESS)-1];

    always @(posedge clk) begin
        if (bus.o_rd_en) bus.i_mem_data <= mem[bus.o_readAdd];
    end

    // ------------------------------------------------------------------
    // scoreboard
    // ------------------------------------------------------------------
    logic [RAM_WIDTH-1:0]  exp_q[$];
    logic [NB_ADDRESS-1:0] addr_q[$];
    int                    req_cyc_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;
    int ack_cnt  = 0;
    logic prev_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // monitor: sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ack = bus.o_ack;
        end else begin
            if (bus.o_rd_en) begin
                rd_cnt++;
                check("rd_expected", 32'(addr_q.size() != 0), 32'd1);
                if (addr_q.size() != 0) check("rd_addr", 32'(bus.o_readAdd), 32'(addr_q.pop_front()));
            end
            if (bus.o_ack !== prev_ack) begin
                ack_cnt++;
                check("ack_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("data", 32'(bus.o_data), 32'(exp_q.pop_front()));
                    check("ack_latency", 32'(cyc - req_cyc_q.pop_front()), 32'd3);
                end
                prev_ack = bus.o_ack;
            end
        end
    end

    // ------------------------------------------------------------------
    // driver tasks (all drives land 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input int len);
        bus.i_start  = 1'b1;
        bus.i_length = NB_IMAGE'(len);
        tick(1);
        bus.i_start  = 1'b0;
    endtask

    // Toggle the request; a serviced request records the word it should return.
    task automatic toggle_req(input logic serviced, input int a);
        bus.i_req = ~bus.i_req;
        if (serviced) begin
            exp_q.push_back(mem[a]);
            addr_q.push_back(NB_ADDRESS'(a));
            req_cyc_q.push_back(cyc);
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (bus.o_done !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check("done_within_budget", 32'(bus.o_done), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_readAdd"}, 32'(bus.o_readAdd), 32'd0);
        check({tag, "_rd_en"},   32'(bus.o_rd_en),   32'd0);
        check({tag, "_data"},    32'(bus.o_data),    32'd0);
        check({tag, "_ack"},     32'(bus.o_ack),     32'd0);
        check({tag, "_busy"},    32'(bus.o_busy),    32'd0);
        check({tag, "_done"},    32'(bus.o_done),    32'd0);
        check({tag, "_overrun"}, 32'(bus.o_overrun), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // directed sequence
    // ------------------------------------------------------------------
    initial begin
        int r0, a0;
        logic ack_save;

        rst_n          = 1'b0;
        bus.i_start    = 1'b0;
        bus.i_length   = '0;
        bus.i_abort    = 1'b0;
        bus.i_req      = 1'b0;
        bus.i_mem_data = '0;
        for (int a = 0; a < (1 << NB_ADDRESS); a++) mem[a] = RAM_WIDTH'(a + 1);

        // reset state
        tick(3);
        check_all_zero("reset");
        check("reset_state", 32'(bus.o_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick(2);

        // request toggles in IDLE are ignored
        r0 = rd_cnt;
        toggle_req(1'b0, 0); tick(5);
        toggle_req(1'b0, 0); tick(1);
        toggle_req(1'b0, 0); tick(5);
        check("idle_no_rd", 32'(rd_cnt - r0), 32'd0);
        check("idle_overrun", 32'(bus.o_overrun), 32'd0);
        check("idle_ack", 32'(bus.o_ack), 32'd0);
        // re-align the MCU phase: ack is 0, so request level must return to 0
        if (bus.i_req) begin toggle_req(1'b0, 0); tick(3); end

        // basic transfer of four words
        start(4);
        check("basic_busy", 32'(bus.o_busy), 32'd1);
        check("basic_armed", 32'(bus.o_state), 32'(ST_ARMED));
        for (int i = 0; i < 4; i++) begin
            toggle_req(1'b1, i);
            tick(10);
        end
        check("basic_done", 32'(bus.o_done), 32'd1);
        check("basic_busy_low", 32'(bus.o_busy), 32'd0);
        check("basic_last_data", 32'(bus.o_data), 32'h4);
        check("basic_last_addr", 32'(bus.o_readAdd), 32'd3);
        check("basic_ack_phase", 32'(bus.o_ack), 32'(bus.i_req));

        // zero length: done immediately, never a read
        r0 = rd_cnt;
        start(0);
        check("zero_done", 32'(bus.o_done), 32'd1);
        check("zero_busy", 32'(bus.o_busy), 32'd0);
        tick(8);
        check("zero_no_rd", 32'(rd_cnt - r0), 32'd0);

        // overrun: second toggle one cycle after the first
        start(2);
        r0 = rd_cnt; a0 = ack_cnt;
        toggle_req(1'b1, 0); tick(1);
        toggle_req(1'b0, 0); tick(10);
        check("ovr_flag", 32'(bus.o_overrun), 32'd1);
        check("ovr_one_read", 32'(rd_cnt - r0), 32'd1);
        check("ovr_one_ack", 32'(ack_cnt - a0), 32'd1);
        check("ovr_still_busy", 32'(bus.o_busy), 32'd1);
        toggle_req(1'b1, 1); tick(2);
        wait_done(20);
        check("ovr_sticky", 32'(bus.o_overrun), 32'd1);
        start(1);
        check("ovr_cleared", 32'(bus.o_overrun), 32'd0);
        toggle_req(1'b1, 0); tick(2);
        wait_done(20);
        if (bus.i_req !== bus.o_ack) begin toggle_req(1'b0, 0); tick(3); end

        // abort after 2 of 5 words
        start(5);
        toggle_req(1'b1, 0); tick(10);
        toggle_req(1'b1, 1); tick(10);
        ack_save = bus.o_ack;
        bus.i_abort = 1'b1;
        tick(1);
        bus.i_abort = 1'b0;
        check("abort_state", 32'(bus.o_state), 32'(ST_IDLE));
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        check("abort_done", 32'(bus.o_done), 32'd0);
        check("abort_addr", 32'(bus.o_readAdd), 32'd0);
        check("abort_data_hold", 32'(bus.o_data), 32'h2);
        check("abort_ack_hold", 32'(bus.o_ack), 32'(ack_save));
        check("abort_overrun", 32'(bus.o_overrun), 32'd0);
        start(1);
        toggle_req(1'b1, 0); tick(2);
        wait_done(20);
        check("abort_restart_data", 32'(bus.o_data), 32'h1);

        // asynchronous reset during a transfer
        start(3);
        toggle_req(1'b1, 0);
        tick(1);                 // READ: strobe checked by the monitor
        @(posedge clk); #2;      // now in LATCH
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        addr_q.delete();
        req_cyc_q.delete();
        tick(2);
        rst_n = 1'b1;
        if (bus.i_req) begin bus.i_req = 1'b0; end
        tick(3);

        // full depth: 1023 words holding their own address
        for (int a = 0; a < (1 << NB_ADDRESS); a++) mem[a] = RAM_WIDTH'(a);
        r0 = rd_cnt;
        start(1023);
        for (int i = 0; i < 1023; i++) begin
            toggle_req(1'b1, i);
            tick(4);
        end
        wait_done(20);
        check("full_reads", 32'(rd_cnt - r0), 32'd1023);
        check("full_last_addr", 32'(bus.o_readAdd), 32'd1022);
        check("full_last_data", 32'(bus.o_data), 32'd1022);
        check("full_overrun", 32'(bus.o_overrun), 32'd0);

        tick(5);
        check("sb_data_empty", 32'(exp_q.size()), 32'd0);
        check("sb_addr_empty", 32'(addr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
